clock_core_param: RTL and testbench

Parametrised successor to the fixed digital clock. It provides an HH:MM:SS timekeeper with a configurable tick divider and a set mode driven by edge-detected buttons. It adds a 12/24-hour display mode, an hourly chime, a programmable alarm and a multiplexed 6-digit seven-segment scan. It sits between the board clock/buttons and the 8-digit segment display plus buzzer.

---
 rtl/clock_core_param.sv | 216 +++++++++++++++++++++
 tb/tb_clock_core_param.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_core_param.sv
// HH:MM:SS timekeeper with set mode, 12/24h display, hourly chime, alarm and 6-digit segment scan.
// Latency: time fields update on the tick edge; bell and segment outputs are registered one cycle after the state they reflect.
// Backpressure: none; free-running, all inputs sampled every clk_src edge.
module clock_core_param #(
    parameter int TICK_DIV   = 100000000,
    parameter int SCAN_DIV   = 100000,
    parameter int CHIME_SECS = 5,
    parameter int ALARM_SECS = 30
) (
    input  logic       clk_src,
    input  logic       sig_reset,
    input  logic       power,
    input  logic       switch_en,
    input  logic       sig_up_sec,
    input  logic       sig_up_min,
    input  logic       sig_up_hour,
    input  logic       mode_12h,
    input  logic       alarm_en,
    input  logic [4:0] alarm_hour,
    input  logic [5:0] alarm_min,
    output logic       bell,
    output logic [7:0] seg_control,
    output logic [7:0] seg_time,
    output logic [4:0] hour_o,
    output logic [5:0] min_o,
    output logic [5:0] sec_o
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int SW = $clog2(SCAN_DIV + 1);
    localparam int CW = $clog2(CHIME_SECS + 1);
    localparam int AW = $clog2(ALARM_SECS + 1);

    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [TW-1:0] TICK_ONE   = TW'(1);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] SCAN_ONE   = SW'(1);
    localparam logic [CW-1:0] CHIME_LOAD = CW'(CHIME_SECS);
    localparam logic [CW-1:0] CHIME_ONE  = CW'(1);
    localparam logic [AW-1:0] ALARM_LOAD = AW'(ALARM_SECS);
    localparam logic [AW-1:0] ALARM_ONE  = AW'(1);

    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [5:0]    sec_q, sec_d, min_q, min_d;
    logic [4:0]    hour_q, hour_d;
    logic [2:0]    btn_q;
    logic [CW-1:0] chime_q, chime_d;
    logic [AW-1:0] alarm_q, alarm_d;
    logic [SW-1:0] scan_cnt_q, scan_cnt_d;
    logic [2:0]    digit_q, digit_d;
    logic          bell_q, bell_d;
    logic [7:0]    seg_ctl_q, seg_ctl_d, seg_q, seg_d;

    logic       run, tick, set_act, hour_roll;
    logic [2:0] btn_edge;

    // Active-low 7-segment pattern for one decimal digit.
    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'd0: return 8'hC0;
            4'd1: return 8'hF9;
            4'd2: return 8'hA4;
            4'd3: return 8'hB0;
            4'd4: return 8'h99;
            4'd5: return 8'h92;
            4'd6: return 8'h82;
            4'd7: return 8'hF8;
            4'd8: return 8'h80;
            4'd9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    // Tick divider: counts only while powered and running, otherwise parked at zero.
    always_comb begin
        run        = power & switch_en;
        tick       = run && (tick_cnt_q == TICK_LAST);
        tick_cnt_d = '0;
        if (run && !tick) tick_cnt_d = tick_cnt_q + TICK_ONE;
    end

    // Time next-state: carrying count on tick, independent per-field increments on button edges in set mode.
    always_comb begin
        btn_edge  = {sig_up_hour, sig_up_min, sig_up_sec} & ~btn_q;
        set_act   = power & ~switch_en;
        sec_d     = sec_q;
        min_d     = min_q;
        hour_d    = hour_q;
        hour_roll = 1'b0;
        if (tick) begin
            if (sec_q == 6'd59) begin
                sec_d = 6'd0;
                if (min_q == 6'd59) begin
                    min_d     = 6'd0;
                    hour_roll = 1'b1;
                    hour_d    = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
                end else begin
                    min_d = min_q + 6'd1;
                end
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end else if (set_act) begin
            if (btn_edge[0]) sec_d  = (sec_q  == 6'd59) ? 6'd0 : sec_q  + 6'd1;
            if (btn_edge[1]) min_d  = (min_q  == 6'd59) ? 6'd0 : min_q  + 6'd1;
            if (btn_edge[2]) hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
        end
    end

    // Chime and alarm countdowns; both only move on ticks, so set mode freezes them.
    always_comb begin
        chime_d = chime_q;
        if (tick && hour_roll)          chime_d = CHIME_LOAD;
        else if (tick && chime_q != '0) chime_d = chime_q - CHIME_ONE;

        alarm_d = alarm_q;
        if (!alarm_en)
            alarm_d = '0;
        else if (tick && sec_d == 6'd0 && min_d == alarm_min && hour_d == alarm_hour)
            alarm_d = ALARM_LOAD;
        else if (tick && alarm_q != '0)
            alarm_d = alarm_q - ALARM_ONE;

        bell_d = (chime_q != '0 || alarm_q != '0) && power;
    end

    // Digit scan and segment decode; outputs come from the same digit index so select and pattern stay aligned.
    always_comb begin
        logic [5:0] s_t, s_o, m_t, m_o;
        logic [4:0] hd, h_t, h_o;
        logic [3:0] val;
        logic       dp;

        scan_cnt_d = scan_cnt_q;
        digit_d    = digit_q;
        if (power) begin
            if (scan_cnt_q == SCAN_LAST) begin
                scan_cnt_d = '0;
                digit_d    = (digit_q == 3'd5) ? 3'd0 : digit_q + 3'd1;
            end else begin
                scan_cnt_d = scan_cnt_q + SCAN_ONE;
            end
        end

        hd = hour_q;
        if (mode_12h) begin
            if (hour_q == 5'd0)       hd = 5'd12;
            else if (hour_q > 5'd12)  hd = hour_q - 5'd12;
        end
        s_t = sec_q / 6'd10;
        s_o = sec_q % 6'd10;
        m_t = min_q / 6'd10;
        m_o = min_q % 6'd10;
        h_t = hd / 5'd10;
        h_o = hd % 5'd10;

        val = 4'd0;
        dp  = 1'b0;
        case (digit_q)
            3'd0: val = s_o[3:0];
            3'd1: val = s_t[3:0];
            3'd2: begin val = m_o[3:0]; dp = 1'b1; end
            3'd3: val = m_t[3:0];
            3'd4: begin val = h_o[3:0]; dp = mode_12h && (hour_q >= 5'd12); end
            3'd5: val = h_t[3:0];
            default: val = 4'd0;
        endcase

        seg_ctl_d = ~(8'h01 << digit_q);
        seg_d     = seg7(val);
        if (dp) seg_d[7] = 1'b0;
        if (!power) begin
            seg_ctl_d = 8'hFF;
            seg_d     = 8'hFF;
        end
    end

    // State registers with synchronous reset; button history tracks inputs even when unpowered.
    always_ff @(posedge clk_src) begin
        if (sig_reset) begin
            tick_cnt_q <= '0;
            sec_q      <= 6'd0;
            min_q      <= 6'd0;
            hour_q     <= 5'd0;
            btn_q      <= 3'b000;
            chime_q    <= '0;
            alarm_q    <= '0;
            scan_cnt_q <= '0;
            digit_q    <= 3'd0;
            bell_q     <= 1'b0;
            seg_ctl_q  <= 8'hFE;
            seg_q      <= 8'hC0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            sec_q      <= sec_d;
            min_q      <= min_d;
            hour_q     <= hour_d;
            btn_q      <= {sig_up_hour, sig_up_min, sig_up_sec};
            chime_q    <= chime_d;
            alarm_q    <= alarm_d;
            scan_cnt_q <= scan_cnt_d;
            digit_q    <= digit_d;
            bell_q     <= bell_d;
            seg_ctl_q  <= seg_ctl_d;
            seg_q      <= seg_d;
        end
    end

    assign bell        = bell_q;
    assign seg_control = seg_ctl_q;
    assign seg_time    = seg_q;
    assign hour_o      = hour_q;
    assign min_o       = min_q;
    assign sec_o       = sec_q;

endmodule

// File: tb/tb_clock_core_param.sv
// Directed + randomized bench for clock_core_param with a seconds-of-day reference model.
module tb_clock_core_param;
    localparam int TD = 4;
    localparam int SD = 2;
    localparam int CS = 2;
    localparam int AS = 3;

    typedef logic [7:0] segarr_t [6];

    logic       clk_src = 1'b0;
    logic       sig_reset, power, switch_en, sig_up_sec, sig_up_min, sig_up_hour;
    logic       mode_12h, alarm_en;
    logic [4:0] alarm_hour;
    logic [5:0] alarm_min;
    logic       bell;
    logic [7:0] seg_control, seg_time;
    logic [4:0] hour_o;
    logic [5:0] min_o, sec_o;

    int vectors = 0;
    int errors  = 0;
    int m_h = 0, m_m = 0, m_s = 0;
    logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    clock_core_param #(.TICK_DIV(TD), .SCAN_DIV(SD), .CHIME_SECS(CS), .ALARM_SECS(AS)) dut (
        .clk_src(clk_src), .sig_reset(sig_reset), .power(power), .switch_en(switch_en),
        .sig_up_sec(sig_up_sec), .sig_up_min(sig_up_min), .sig_up_hour(sig_up_hour),
        .mode_12h(mode_12h), .alarm_en(alarm_en), .alarm_hour(alarm_hour), .alarm_min(alarm_min),
        .bell(bell), .seg_control(seg_control), .seg_time(seg_time),
        .hour_o(hour_o), .min_o(min_o), .sec_o(sec_o)
    );

    always #5 clk_src = ~clk_src;

    task automatic step(input int n);
        repeat (n) @(posedge clk_src);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_time(input string tag);
        check({tag, "_hour"}, 32'(hour_o), m_h);
        check({tag, "_min"},  32'(min_o),  m_m);
        check({tag, "_sec"},  32'(sec_o),  m_s);
    endtask

    // Reference: time as seconds of day advanced by whole ticks.
    task automatic advance(input int ticks);
        int t;
        t   = (m_h * 3600 + m_m * 60 + m_s + ticks) % 86400;
        m_h = t / 3600;
        m_m = (t / 60) % 60;
        m_s = t % 60;
    endtask

    task automatic run_cycles(input int n);
        switch_en = 1'b1;
        step(n);
        switch_en = 1'b0;
        step(1);
        advance(n / TD);
    endtask

    task automatic pulse(input logic [2:0] mask);
        {sig_up_hour, sig_up_min, sig_up_sec} = mask;
        step(1);
        {sig_up_hour, sig_up_min, sig_up_sec} = 3'b000;
        step(1);
        if (mask[0]) m_s = (m_s + 1) % 60;
        if (mask[1]) m_m = (m_m + 1) % 60;
        if (mask[2]) m_h = (m_h + 1) % 24;
    endtask

    task automatic set_time(input int h, input int m, input int s);
        int nh, nm, ns;
        nh = (h - m_h + 24) % 24;
        nm = (m - m_m + 60) % 60;
        ns = (s - m_s + 60) % 60;
        for (int i = 0; i < nh; i++) pulse(3'b100);
        for (int i = 0; i < nm; i++) pulse(3'b010);
        for (int i = 0; i < ns; i++) pulse(3'b001);
    endtask

    task automatic model_digits(output segarr_t e);
        int hd;
        int v [6];
        hd = m_h;
        if (mode_12h) hd = (m_h % 12 == 0) ? 12 : m_h % 12;
        v = '{m_s % 10, m_s / 10, m_m % 10, m_m / 10, hd % 10, hd / 10};
        for (int i = 0; i < 6; i++) begin
            e[i] = seg_tab[v[i]];
            if (i == 2) e[i][7] = 1'b0;
            if (i == 4 && mode_12h && m_h >= 12) e[i][7] = 1'b0;
        end
    endtask

    task automatic check_scan(input string tag, input segarr_t e);
        logic [7:0] prev, c;
        logic       found;
        prev  = seg_control;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(1);
            if (seg_control == 8'hFE && prev != 8'hFE) found = 1'b1;
            else prev = seg_control;
        end
        check({tag, "_sync"}, 32'(found), 1);
        if (found) begin
            for (int d = 0; d < 6; d++) begin
                c = ~(8'h01 << d);
                for (int k = 0; k < SD; k++) begin
                    check({tag, "_ctl"}, 32'(seg_control), 32'(c));
                    check({tag, "_seg"}, 32'(seg_time), 32'(e[d]));
                    step(1);
                end
            end
        end
    endtask

    initial begin
        segarr_t e;
        int n;
        logic [2:0] mask;

        sig_reset = 1'b1; power = 1'b1; switch_en = 1'b0;
        sig_up_sec = 1'b0; sig_up_min = 1'b0; sig_up_hour = 1'b0;
        mode_12h = 1'b0; alarm_en = 1'b0; alarm_hour = 5'd0; alarm_min = 6'd0;
        step(2);
        check_time("rst");
        check("rst_bell", 32'(bell), 0);
        check("rst_ctl", 32'(seg_control), 32'h FE);
        check("rst_seg", 32'(seg_time), 32'h C0);

        // 1: free run, ticks every TD cycles
        sig_reset = 1'b0; switch_en = 1'b1;
        step(TD - 1);
        check("tick_early", 32'(sec_o), 0);
        step(1);
        check("tick_first", 32'(sec_o), 1);
        step(TD);
        check("tick_second", 32'(sec_o), 2);
        step(240 - 2 * TD);
        switch_en = 1'b0;
        step(1);
        advance(240 / TD);
        check_time("run240");
        check("run240_bell", 32'(bell), 0);

        // 2: set mode increments
        for (int i = 0; i < 10; i++) pulse(3'b001);
        for (int i = 0; i < 4; i++) pulse(3'b110);
        check_time("set_pulses");
        sig_up_sec = 1'b1;
        step(20);
        sig_up_sec = 1'b0;
        step(1);
        m_s = (m_s + 1) % 60;
        check_time("set_held");
        set_time(m_h, m_m, 59);
        pulse(3'b001);
        check_time("set_sec_wrap");

        // 3: hourly chime
        set_time(0, 59, 58);
        switch_en = 1'b1;
        step(2 * TD);
        check("chime_roll_hour", 32'(hour_o), 1);
        check("chime_pre", 32'(bell), 0);
        step(1);
        check("chime_rise", 32'(bell), 1);
        step(CS * TD - 1);
        check("chime_hold", 32'(bell), 1);
        step(1);
        check("chime_fall", 32'(bell), 0);
        switch_en = 1'b0;
        step(1);
        advance(4);
        check_time("chime_after");

        // 4: alarm coinciding with chime, then disabled mid-ring
        set_time(0, 59, 58);
        alarm_hour = 5'd1; alarm_min = 6'd0; alarm_en = 1'b1;
        switch_en = 1'b1;
        step(2 * TD + 1);
        check("alarm_rise", 32'(bell), 1);
        step(CS * TD);
        check("alarm_outlasts_chime", 32'(bell), 1);
        alarm_en = 1'b0;
        step(2);
        check("alarm_disabled", 32'(bell), 0);
        switch_en = 1'b0;
        step(1);
        advance(4);
        check_time("alarm_after");

        // 5: 12-hour display scan
        mode_12h = 1'b1;
        set_time(13, 5, 9);
        check_scan("pm1305", '{8'h90, 8'hC0, 8'h12, 8'hC0, 8'h79, 8'hC0});
        set_time(0, 5, 9);
        model_digits(e);
        check_scan("midnight12", e);
        mode_12h = 1'($urandom_range(0, 1));
        set_time($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
        model_digits(e);
        check_scan("rand_disp", e);

        // 6: power loss during alarm, power-up with held button, reset
        set_time(0, 59, 58);
        alarm_en = 1'b1;
        switch_en = 1'b1;
        step(2 * TD + 2);
        check("pwr_bell_on", 32'(bell), 1);
        power = 1'b0;
        step(1);
        check("pwr_bell_off", 32'(bell), 0);
        check("pwr_ctl", 32'(seg_control), 32'h FF);
        check("pwr_seg", 32'(seg_time), 32'h FF);
        advance(2);
        step(20);
        check_time("pwr_frozen");
        switch_en = 1'b0;
        sig_up_min = 1'b1;
        step(2);
        power = 1'b1;
        step(4);
        check_time("pwr_held_btn");
        check("pwr_bell_resume", 32'(bell), 1);
        sig_up_min = 1'b0;
        step(1);
        sig_reset = 1'b1;
        step(1);
        m_h = 0; m_m = 0; m_s = 0;
        check_time("reset_mid");
        check("reset_mid_bell", 32'(bell), 0);
        check("reset_mid_ctl", 32'(seg_control), 32'h FE);
        check("reset_mid_seg", 32'(seg_time), 32'h C0);
        sig_reset = 1'b0;
        alarm_en = 1'b0;

        // Random set/run mixes against the reference model
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(0, 12);
            for (int i = 0; i < n; i++) begin
                mask = 3'($urandom_range(1, 7));
                pulse(mask);
            end
            run_cycles($urandom_range(5, 400));
            check_time("rand_mix");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
